// File: rtl/sm83_fetch.sv
// SM83 instruction fetch: byte bus in, one decoded-length instruction bundle out per valid/ready handoff.
// Optional macro SM83_FETCH_ILLEGAL_TRAP_EN: flag unused opcodes and stall fetch after handing them off.
module sm83_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        redir_valid,
  input  logic [15:0] redir_pc,
  input  logic        hold,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [7:0]  dec_op,
  output logic        dec_cb,
  output logic [15:0] dec_imm,
  output logic [1:0]  dec_imm_len,
  output logic [15:0] dec_pc,
  output logic        dec_illegal
);

  typedef enum logic [2:0] {
    S_OP     = 3'd0,
    S_CB     = 3'd1,
    S_IMM_LO = 3'd2,
    S_IMM_HI = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] r_dpc;
  logic [15:0] r_imm;
  logic [7:0]  r_op;
  logic [1:0]  r_len;
  logic        r_cb;
  logic        r_ill;
  logic        r_stall;
  logic        r_launched;
  logic        w_take;
  logic        w_illegal;
  logic [1:0]  w_len;

  function automatic logic [1:0] imm_len(input logic [7:0] op);
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8:                         imm_len = 2'd1;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
      8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:           imm_len = 2'd2;
      default:                                            imm_len = 2'd0;
    endcase
  endfunction

`ifdef SM83_FETCH_ILLEGAL_TRAP_EN
  function automatic logic is_illegal(input logic [7:0] op);
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: is_illegal = 1'b1;
      default:                           is_illegal = 1'b0;
    endcase
  endfunction
  assign w_illegal = is_illegal(mem_rdata);
`else
  assign w_illegal = 1'b0;
`endif

  assign w_len       = w_illegal ? 2'd0 : imm_len(mem_rdata);
  // A redirect in the same cycle as an ack discards the byte.
  assign w_take      = mem_req && mem_ack && !redir_valid;
  assign mem_addr    = r_pc;
  assign dec_valid   = (r_state == S_OUT);
  assign dec_op      = r_op;
  assign dec_cb      = r_cb;
  assign dec_imm     = r_imm;
  assign dec_imm_len = r_len;
  assign dec_pc      = r_dpc;
  assign dec_illegal = r_ill;

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    case (r_state)
      S_OP: begin
        mem_req = r_launched;
        if (w_take) begin
          if (mem_rdata == 8'hCB)  w_state_nxt = S_CB;
          else if (w_len == 2'd0)  w_state_nxt = S_OUT;
          else                     w_state_nxt = S_IMM_LO;
        end
      end
      S_CB: begin
        mem_req = 1'b1;
        if (w_take) w_state_nxt = S_OUT;
      end
      S_IMM_LO: begin
        mem_req = 1'b1;
        if (w_take) w_state_nxt = (r_len == 2'd2) ? S_IMM_HI : S_OUT;
      end
      S_IMM_HI: begin
        mem_req = 1'b1;
        if (w_take) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (dec_ready) w_state_nxt = S_OP;
      end
      default: w_state_nxt = S_OP;
    endcase
    if (redir_valid) w_state_nxt = S_OP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_OP;
    else        r_state <= w_state_nxt;
  end

  // Request launch is registered so hold is only sampled before a request goes out
  // and async reset drops an outstanding request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_launched <= 1'b0;
    end else if (redir_valid || r_state != S_OP || w_take) begin
      r_launched <= 1'b0;
    end else if (!r_launched) begin
      r_launched <= !hold && !r_stall;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_dpc   <= 16'h0000;
      r_imm   <= 16'h0000;
      r_op    <= 8'h00;
      r_len   <= 2'd0;
      r_cb    <= 1'b0;
      r_ill   <= 1'b0;
      r_stall <= 1'b0;
    end else if (redir_valid) begin
      r_pc    <= redir_pc;
      r_ill   <= 1'b0;
      r_stall <= 1'b0;
    end else if (w_take) begin
      r_pc <= r_pc + 16'd1;
      case (r_state)
        S_OP: begin
          r_dpc <= r_pc;
          r_op  <= mem_rdata;
          r_imm <= 16'h0000;
          r_cb  <= (mem_rdata == 8'hCB);
          r_len <= (mem_rdata == 8'hCB) ? 2'd0 : w_len;
          r_ill <= w_illegal;
        end
        S_CB:     r_op        <= mem_rdata;
        S_IMM_LO: r_imm[7:0]  <= mem_rdata;
        S_IMM_HI: r_imm[15:8] <= mem_rdata;
        default:  r_op        <= r_op;
      endcase
    end else if (r_state == S_OUT && dec_ready && r_ill) begin
      r_stall <= 1'b1;
    end
  end

endmodule
